// File: rtl/rms_sequencer_if.sv
// Shared instruction/data memory port between the sequencer and the memory.
// The sequencer holds mem_req until mem_ack, a single-cycle pulse, completes the transfer.
interface rms_sequencer_if;
    logic mem_req;       // transfer request, held until acknowledged
    logic mem_we;        // write qualifier for mem_req
    logic mem_addr_src;  // 0 = PC, 1 = ALUout
    logic mem_ack;       // transfer done, one-cycle pulse

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_src,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_src,
        output mem_ack
    );
endinterface

// File: rtl/rms_sequencer.sv
// rms_sequencer: multi-cycle Moore control FSM for the 16-bit core.
// It decodes the opcode and steps through fetch, immediate fetch, execute,
// memory and write-back phases. At each phase it drives the register-management
// strobes and the PC, IR, ALU and memory controls. Every output is a registered
// decode of the next state, so the outputs change only on clock edges.
module rms_sequencer #(
    parameter int OPW         = 4,
    parameter int ALUOPW      = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    rms_sequencer_if.master   memBus,
    input  logic [OPW-1:0]    op,
    input  logic              cmp_result,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              ir_write,
    output logic              writeImR,
    output logic              RegR1,
    output logic              RegR2,
    output logic              RegW1,
    output logic              RegW2,
    output logic              writeCR,
    output logic [1:0]        RegSrc,
    output logic              ALUsrc,
    output logic [ALUOPW-1:0] ALUop,
    output logic              cmpne,
    output logic              cmpeq,
    output logic              save,
    output logic              restore,
    output logic              halted,
    output logic              bus_err
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
        OP_SLT  = 4'h4, OP_ADDI = 4'h5, OP_LW = 4'h6, OP_SW  = 4'h7,
        OP_BEQ  = 4'h8, OP_BNE = 4'h9, OP_JAL = 4'hA, OP_RET = 4'hB,
        OP_IN   = 4'hC, OP_OUT = 4'hD, OP_LI  = 4'hE, OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_IMM, S_EXEC, S_MEM,
        S_WB, S_WB_CR, S_BR, S_JMP, S_HALT
    } state_t;

    // All registered control outputs, cleared as a group on reset.
    typedef struct packed {
        logic              memReq;
        logic              memWe;
        logic              memAddrSrc;
        logic              pcWrite;
        logic [1:0]        pcSrc;
        logic              irWrite;
        logic              writeImR;
        logic              regR1;
        logic              regR2;
        logic              regW1;
        logic              regW2;
        logic              writeCR;
        logic [1:0]        regSrc;
        logic              aluSrc;
        logic [ALUOPW-1:0] aluOp;
        logic              cmpne;
        logic              cmpeq;
        logic              save;
        logic              restore;
        logic              halted;
    } ctrl_t;

    localparam logic [1:0] PC_INC = 2'b00;  // PC + 1
    localparam logic [1:0] PC_BR  = 2'b01;  // branch target
    localparam logic [1:0] PC_REG = 2'b10;  // A (jump / return)

    localparam logic [1:0] SRC_IMR = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_ALU = 2'b10;
    localparam logic [1:0] SRC_A   = 2'b11;

    localparam int             CNTW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNTW-1:0] LAST_WAIT = CNTW'(MEM_TIMEOUT - 1);

    state_t          state;
    state_t          nextState;
    ctrl_t           ctrl;
    ctrl_t           nxt;
    logic [CNTW-1:0] waitCnt;
    logic [3:0]      opc;
    logic            memState;
    logic            ackTaken;
    logic            waiting;
    logic            timeoutHit;

    assign opc = op[3:0];

    // An ack counts only while a request is actually on the bus. This filters
    // stray acks outside memory states and acks that outlive a reset.
    assign memState   = (state == S_FETCH) || (state == S_IMM) || (state == S_MEM);
    assign ackTaken   = memState && memBus.mem_req && memBus.mem_ack;
    assign waiting    = memState && memBus.mem_req && !memBus.mem_ack;
    assign timeoutHit = waiting && (waitCnt == LAST_WAIT);

    // Controls presented on entry to EXEC; the ALU adds A+imm for ADDI/LW/SW.
    function automatic ctrl_t execCtrl(input logic [3:0] code);
        ctrl_t c;
        c = '0;
        case (code)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                c.aluSrc = 1'b1;
                c.aluOp  = ALUOPW'(code[2:0]);
            end
            OP_BEQ: c.cmpeq   = 1'b1;
            OP_BNE: c.cmpne   = 1'b1;
            OP_JAL: c.save    = 1'b1;
            OP_RET: c.restore = 1'b1;
            OP_IN: begin
                c.regW2  = 1'b1;
                c.regSrc = SRC_A;
            end
            OP_OUT: c.regW1 = 1'b1;
            OP_LI: begin
                c.regW2  = 1'b1;
                c.regSrc = SRC_IMR;
            end
            default: c.aluSrc = 1'b0;
        endcase
        return c;
    endfunction

    // Data-phase request: address from ALUout, write only for SW.
    function automatic ctrl_t memCtrl(input logic [3:0] code);
        ctrl_t c;
        c            = '0;
        c.memReq     = 1'b1;
        c.memAddrSrc = 1'b1;
        c.memWe      = (code == OP_SW);
        return c;
    endfunction

    // Next-state and next-output decode.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        nextState = state;
        nxt       = '0;
        if (timeoutHit) begin
            nextState  = S_HALT;
            nxt.halted = 1'b1;
        end else begin
            case (state)
                S_FETCH: begin
                    if (ackTaken) begin
                        nextState   = S_DECODE;
                        nxt.irWrite = 1'b1;
                        nxt.pcWrite = 1'b1;
                        nxt.regR1   = 1'b1;
                        nxt.regR2   = 1'b1;
                    end else begin
                        // Also raises the request after reset or after the SW gap cycle.
                        nxt.memReq = 1'b1;
                    end
                end
                S_DECODE: begin
                    case (opc)
                        OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL, OP_LI: begin
                            nextState  = S_IMM;
                            nxt.memReq = 1'b1;
                        end
                        OP_HALT: begin
                            nextState  = S_HALT;
                            nxt.halted = 1'b1;
                        end
                        default: begin
                            nextState = S_EXEC;
                            nxt       = execCtrl(opc);
                        end
                    endcase
                end
                S_IMM: begin
                    if (ackTaken) begin
                        nextState    = S_EXEC;
                        nxt          = execCtrl(opc);
                        nxt.writeImR = 1'b1;
                        nxt.pcWrite  = 1'b1;
                    end else begin
                        nxt.memReq = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (opc)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                            nextState  = S_WB;
                            nxt.regW2  = 1'b1;
                            nxt.regSrc = SRC_ALU;
                        end
                        OP_SLT: begin
                            // AltB result goes to CR (r57) through write port 1.
                            nextState   = S_WB_CR;
                            nxt.regW1   = 1'b1;
                            nxt.writeCR = 1'b1;
                        end
                        OP_LW, OP_SW: begin
                            nextState = S_MEM;
                            nxt       = memCtrl(opc);
                        end
                        OP_BEQ, OP_BNE: begin
                            nextState = S_BR;
                            if (cmp_result) begin
                                nxt.pcWrite = 1'b1;
                                nxt.pcSrc   = PC_BR;
                            end
                        end
                        OP_JAL: begin
                            // Link value reaches write port 2 through the ALU output path.
                            nextState   = S_JMP;
                            nxt.pcWrite = 1'b1;
                            nxt.pcSrc   = PC_REG;
                            nxt.regW2   = 1'b1;
                            nxt.regSrc  = SRC_ALU;
                        end
                        OP_RET: begin
                            nextState   = S_JMP;
                            nxt.pcWrite = 1'b1;
                            nxt.pcSrc   = PC_REG;
                        end
                        default: begin
                            nextState  = S_FETCH;
                            nxt.memReq = 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (ackTaken) begin
                        if (opc == OP_LW) begin
                            nextState  = S_WB;
                            nxt.regW2  = 1'b1;
                            nxt.regSrc = SRC_MEM;
                        end else begin
                            // Enter FETCH with the request low for one cycle to keep a bus gap.
                            nextState = S_FETCH;
                        end
                    end else begin
                        nxt = memCtrl(opc);
                    end
                end
                S_WB, S_WB_CR, S_BR, S_JMP: begin
                    nextState  = S_FETCH;
                    nxt.memReq = 1'b1;
                end
                S_HALT: nxt.halted = 1'b1;
                default: begin
                    nextState  = S_FETCH;
                    nxt.memReq = 1'b1;
                end
            endcase
        end
    end

    // State, registered outputs, wait counter and sticky bus error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_FETCH;
            ctrl    <= '0;
            waitCnt <= '0;
            bus_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state   <= nextState;
            ctrl    <= nxt;
            waitCnt <= (waiting && !timeoutHit) ? waitCnt + CNTW'(1) : '0;
            if (timeoutHit) begin
                bus_err <= 1'b1;
            end
        end
    end

    assign memBus.mem_req      = ctrl.memReq;
    assign memBus.mem_we       = ctrl.memWe;
    assign memBus.mem_addr_src = ctrl.memAddrSrc;
    assign pc_write            = ctrl.pcWrite;
    assign pc_src              = ctrl.pcSrc;
    assign ir_write            = ctrl.irWrite;
    assign writeImR            = ctrl.writeImR;
    assign RegR1               = ctrl.regR1;
    assign RegR2               = ctrl.regR2;
    assign RegW1               = ctrl.regW1;
    assign RegW2               = ctrl.regW2;
    assign writeCR             = ctrl.writeCR;
    assign RegSrc              = ctrl.regSrc;
    assign ALUsrc              = ctrl.aluSrc;
    assign ALUop               = ctrl.aluOp;
    assign cmpne               = ctrl.cmpne;
    assign cmpeq               = ctrl.cmpeq;
    assign save                = ctrl.save;
    assign restore             = ctrl.restore;
    assign halted              = ctrl.halted;

endmodule

// File: tb/tb_rms_sequencer.sv
// Testbench for rms_sequencer. A memory responder acks after a chosen latency.
// Per-instruction strobe counts are compared with a model derived from the
// instruction behaviour (cycle budget, pulse counts, write-back source).
module tb_rms_sequencer;
    localparam int MEM_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] op;
    logic       cmp_result;
    logic       pc_write, ir_write, writeImR, RegR1, RegR2, RegW1, RegW2, writeCR;
    logic [1:0] pc_src, RegSrc;
    logic       ALUsrc, cmpne, cmpeq, save, restore, halted, bus_err;
    logic [2:0] ALUop;

    rms_sequencer_if memBus();

    rms_sequencer #(.OPW(4), .ALUOPW(3), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .memBus(memBus), .op(op), .cmp_result(cmp_result),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .writeImR(writeImR),
        .RegR1(RegR1), .RegR2(RegR2), .RegW1(RegW1), .RegW2(RegW2), .writeCR(writeCR),
        .RegSrc(RegSrc), .ALUsrc(ALUsrc), .ALUop(ALUop), .cmpne(cmpne), .cmpeq(cmpeq),
        .save(save), .restore(restore), .halted(halted), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int reqN, addrSrcN, memWeN, pcInc, pcBr, pcJmp, irWr, imrWr, regR;
        int regW1, regW2, w2Src, writeCR, aluSrcN, aluOpOr, cmpEq, cmpNe, saveN, restoreN;
    } stats_t;

    int     total = 0;
    int     bad   = 0;
    stats_t obs;
    int     latF, latI, latM, reqRun;
    bit     irSeen;

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic logic [24:0] outs();
        return {memBus.mem_req, memBus.mem_we, memBus.mem_addr_src, pc_write, pc_src, ir_write,
                writeImR, RegR1, RegR2, RegW1, RegW2, writeCR, RegSrc, ALUsrc, ALUop,
                cmpne, cmpeq, save, restore, halted, bus_err};
    endfunction

    // Expected per-instruction totals, counted from the first fetch-request cycle to the next one.
    function automatic stats_t model(input int opc, input bit cmp, input int lf, input int li,
                                     input int lm, output int cyc);
        stats_t e;
        bit     imm;
        e   = '{default: 0};
        imm = (opc inside {5, 6, 7, 8, 9, 10, 14});
        cyc = (lf + 1) + 1 + (imm ? li + 1 : 0) + 1;
        e.reqN  = (lf + 1) + (imm ? li + 1 : 0);
        e.irWr  = 1;
        e.regR  = 1;
        e.pcInc = imm ? 2 : 1;
        e.imrWr = imm ? 1 : 0;
        if (opc <= 4) begin
            e.aluSrcN = 1;
            e.aluOpOr = opc;
        end
        case (opc)
            0, 1, 2, 3, 5: begin cyc += 1; e.regW2 = 1; e.w2Src = 2; end
            4:  begin cyc += 1; e.regW1 = 1; e.writeCR = 1; end
            6:  begin cyc += lm + 2; e.reqN += lm + 1; e.addrSrcN = lm + 1; e.regW2 = 1; e.w2Src = 1; end
            7:  begin cyc += lm + 2; e.reqN += lm + 1; e.addrSrcN = lm + 1; e.memWeN = lm + 1; end
            8:  begin cyc += 1; e.cmpEq = 1; e.pcBr = cmp ? 1 : 0; end
            9:  begin cyc += 1; e.cmpNe = 1; e.pcBr = cmp ? 1 : 0; end
            10: begin cyc += 1; e.saveN = 1; e.pcJmp = 1; e.regW2 = 1; e.w2Src = 2; end
            11: begin cyc += 1; e.restoreN = 1; e.pcJmp = 1; end
            12: begin e.regW2 = 1; e.w2Src = 3; end
            13: e.regW1 = 1;
            default: e.regW2 = 1;  // LI, source ImR (0)
        endcase
        return e;
    endfunction

    // Sample one cycle at the negedge, drive the memory ack for the coming posedge, advance.
    task automatic tick();
        int  lat;
        logic ack;
        if (memBus.mem_req)      obs.reqN++;
        if (memBus.mem_addr_src) obs.addrSrcN++;
        if (memBus.mem_we)       obs.memWeN++;
        if (pc_write) begin
            if (pc_src == 2'b00) obs.pcInc++;
            else if (pc_src == 2'b01) obs.pcBr++;
            else if (pc_src == 2'b10) obs.pcJmp++;
            else obs.pcJmp += 100;
        end
        if (ir_write) begin obs.irWr++; irSeen = 1'b1; end
        if (writeImR) obs.imrWr++;
        if (RegR1 && RegR2) obs.regR++;
        if (RegW1) obs.regW1++;
        if (RegW2) begin obs.regW2++; obs.w2Src = int'(RegSrc); end
        if (writeCR) obs.writeCR++;
        if (ALUsrc) obs.aluSrcN++;
        obs.aluOpOr |= int'(ALUop);
        if (cmpeq) obs.cmpEq++;
        if (cmpne) obs.cmpNe++;
        if (save) obs.saveN++;
        if (restore) obs.restoreN++;
        ack = 1'b0;
        if (memBus.mem_req) begin
            lat = memBus.mem_addr_src ? latM : (irSeen ? latI : latF);
            if (reqRun == lat) begin ack = 1'b1; reqRun = 0; end
            else reqRun++;
        end else begin
            reqRun = 0;
        end
        memBus.mem_ack = ack;
        @(negedge clk);
    endtask

    task automatic startPhase(input int lf, input int li, input int lm);
        obs    = '{default: 0};
        irSeen = 1'b0;
        reqRun = 0;
        latF   = lf;
        latI   = li;
        latM   = lm;
    endtask

    // Runs one instruction from a fresh fetch-request cycle and compares its totals.
    task automatic runInstr(input int opc, input bit cmp, input int lf, input int li, input int lm);
        stats_t e;
        int     cyc;
        string  p;
        p = $sformatf("op%0h_c%0d", opc, cmp);
        e = model(opc, cmp, lf, li, lm, cyc);
        startPhase(lf, li, lm);
        op         = 4'(opc);
        cmp_result = cmp;
        for (int c = 0; c < cyc; c++) tick();
        check({p, ".req_cycles"}, obs.reqN, e.reqN);
        check({p, ".addr_src_cycles"}, obs.addrSrcN, e.addrSrcN);
        check({p, ".we_cycles"}, obs.memWeN, e.memWeN);
        check({p, ".pc_inc"}, obs.pcInc, e.pcInc);
        check({p, ".pc_br"}, obs.pcBr, e.pcBr);
        check({p, ".pc_jmp"}, obs.pcJmp, e.pcJmp);
        check({p, ".ir_write"}, obs.irWr, e.irWr);
        check({p, ".writeImR"}, obs.imrWr, e.imrWr);
        check({p, ".reg_read"}, obs.regR, e.regR);
        check({p, ".RegW1"}, obs.regW1, e.regW1);
        check({p, ".RegW2"}, obs.regW2, e.regW2);
        check({p, ".RegSrc"}, obs.w2Src, e.w2Src);
        check({p, ".writeCR"}, obs.writeCR, e.writeCR);
        check({p, ".ALUsrc"}, obs.aluSrcN, e.aluSrcN);
        check({p, ".ALUop"}, obs.aluOpOr, e.aluOpOr);
        check({p, ".cmp"}, obs.cmpEq * 2 + obs.cmpNe, e.cmpEq * 2 + e.cmpNe);
        check({p, ".save_restore"}, obs.saveN * 2 + obs.restoreN, e.saveN * 2 + e.restoreN);
        check({p, ".next_fetch"}, int'({memBus.mem_req, memBus.mem_addr_src, ir_write, halted}), 8);
    endtask

    // Async reset from the current negedge: outputs clear at once, then a fresh fetch request.
    task automatic pulseReset(input string tag);
        memBus.mem_ack = 1'b0;
        #2 reset_n = 1'b0;
        #1 check({tag, ".outs_in_reset"}, int'(outs()), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check({tag, ".fetch_after_reset"}, int'({memBus.mem_req, memBus.mem_addr_src, bus_err, halted}), 8);
    endtask

    initial begin
        int n;
        reset_n        = 1'b0;
        op             = 4'h0;
        cmp_result     = 1'b0;
        memBus.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", int'(outs()), 0);

        // A stale ack in the first cycle after release is ignored.
        reset_n        = 1'b1;
        memBus.mem_ack = 1'b1;
        @(negedge clk);
        memBus.mem_ack = 1'b0;
        check("stale_ack_ignored", int'({memBus.mem_req, ir_write, pc_write}), 4);

        // Reset mid-FETCH while mem_req is high.
        pulseReset("mid_fetch");

        // Directed instructions.
        runInstr(0, 1'b0, 0, 0, 0);    // ADD, zero-wait ack
        runInstr(6, 1'b0, 0, 3, 3);    // LW, 3-cycle ack delay in IMM and MEM
        runInstr(8, 1'b1, 1, 0, 0);    // BEQ taken
        runInstr(9, 1'b0, 0, 2, 0);    // BNE not taken
        runInstr(4, 1'b0, 0, 0, 0);    // SLT
        runInstr(7, 1'b0, 1, 1, 2);    // SW, bus gap before next fetch
        runInstr(10, 1'b0, 0, 0, 0);   // JAL
        runInstr(11, 1'b0, 0, 0, 0);   // RET
        runInstr(12, 1'b0, 0, 0, 0);   // IN
        runInstr(13, 1'b0, 2, 0, 0);   // OUT
        runInstr(14, 1'b0, 0, 1, 0);   // LI
        runInstr(5, 1'b0, 0, 0, 0);    // ADDI

        // Random instruction stream with random ack latencies.
        for (int i = 0; i < 40; i++) begin
            runInstr(int'($urandom_range(0, 14)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 4)));
        end

        // LW with the data ack withheld: timeout after MEM_TIMEOUT request cycles.
        startPhase(0, 0, 999);
        op         = 4'h6;
        cmp_result = 1'b0;
        n          = 0;
        while (halted !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("timeout.mem_cycles", obs.addrSrcN, MEM_TIMEOUT);
        check("timeout.total_cycles", n, 4 + MEM_TIMEOUT);
        check("timeout.outs", int'(outs()), 3);

        // HALT is absorbing: acks and opcode changes do nothing.
        for (int i = 0; i < 8; i++) begin
            op             = 4'($urandom_range(0, 15));
            cmp_result     = 1'($urandom_range(0, 1));
            memBus.mem_ack = 1'(i % 2);
            @(negedge clk);
            check($sformatf("timeout.absorb%0d", i), int'(outs()), 3);
        end

        pulseReset("after_timeout");

        // HALT opcode: FETCH (2-cycle ack delay), DECODE, then HALT.
        startPhase(2, 0, 0);
        op = 4'hF;
        n  = 0;
        while (halted !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("halt_op.cycles", n, 4);
        check("halt_op.outs", int'(outs()), 2);
        for (int i = 0; i < 4; i++) begin
            memBus.mem_ack = 1'b1;
            op             = 4'(i);
            @(negedge clk);
            check($sformatf("halt_op.absorb%0d", i), int'(outs()), 2);
        end
        memBus.mem_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rms_sequencer.md
Name: rms_sequencer

Overview:
- Multi-cycle Moore control FSM for the 16-bit core; sits between instruction/data memory and the register management system.
- Decodes the 4-bit opcode and, per instruction, sequences the RMS control strobes (RegR1/R2, RegW1/W2, writeCR, RegSrc, writeImR, restore) plus the PC, IR, ALU and memory controls.
- Instruction and data memory share one port through a req/ack handshake.

Parameters:
- OPW, 4, opcode width
- ALUOPW, 3, ALU op width
- MEM_TIMEOUT, 15, max cycles to wait for mem_ack before flagging a bus error

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- op  in  OPW  opcode, IR[15:12], from RMS
- cmp_result  in  1  branch compare result from RMS
- mem_ack  in  1  memory transfer done; single-cycle pulse
- mem_req  out  1  memory request; held until ack
- mem_we  out  1  write qualifier for mem_req
- mem_addr_src  out  1  0 = PC, 1 = ALUout
- pc_write  out  1  load PC
- pc_src  out  2  00 = PC+1, 01 = branch target, 10 = A (jump/ret)
- ir_write  out  1  load IR from memory
- writeImR  out  1  load ImR from memory
- RegR1, RegR2, RegW1, RegW2  out  1 each  register file port strobes
- writeCR  out  1  a1 address select, 1 = CR (r57)
- RegSrc  out  2  w2 data: 00 ImR, 01 memOut, 10 ALUout, 11 A
- ALUsrc  out  1  0 = immediate, 1 = B
- ALUop  out  ALUOPW  ALU operation
- cmpne, cmpeq  out  1 each  compare type strobes to RMS
- save, restore  out  1 each  function-context save/restore
- halted  out  1  HALT reached
- bus_err  out  1  sticky memory timeout flag

Behaviour:
- All outputs are registered decodes of the next state.
- Reset value of every output is 0.
- State on reset: FETCH. Reset mid-transaction drops mem_req immediately; an ack that arrives after that is ignored.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 BNE, A JAL, B RET, C IN, D OUT, E LI, F HALT.
- FETCH: mem_req=1, mem_addr_src=0; stays until mem_ack.
  - On ack: ir_write=1, pc_write=1 with pc_src=00, then go to DECODE.
- DECODE: RegR1=RegR2=1.
  - 5, 6, 7, 8, 9, A, E -> IMM.
  - F -> HALT.
  - Otherwise -> EXEC.
- IMM: mem_req from PC; stays until mem_ack.
  - On ack: writeImR=1, pc_write=1 (PC+1), then go to EXEC.
- EXEC:
  - ALU ops 0-4: ALUsrc=1, ALUop=op[2:0].
  - SLT (4) -> WB_CR; other ALU ops -> WB.
  - ADDI: ALUsrc=0, ALUop=000 -> WB.
  - LW, SW: ALUsrc=0, address = A+imm -> MEM.
  - BEQ, BNE: cmpeq or cmpne asserted -> BR.
  - JAL: save=1 -> JMP.
  - RET: restore=1 -> JMP.
  - IN: RegW2 with RegSrc=11 -> FETCH.
  - OUT: RegW1 -> FETCH.
  - LI: RegW2 with RegSrc=00 -> FETCH.
- MEM: mem_req=1, mem_addr_src=1, mem_we=(op==7); stays until mem_ack.
  - LW then -> WB with RegSrc=01.
  - SW then -> FETCH.
- WB: RegW2=1, RegSrc=10 (01 for LW); one cycle, then -> FETCH.
- WB_CR: RegW1=1, writeCR=1 (result AltB lands in r57); one cycle, then -> FETCH.
- BR: if cmp_result, pc_write=1 with pc_src=01; otherwise nothing. Then -> FETCH.
- JMP: pc_write=1 with pc_src=10; JAL also RegW2 with the link value. Then -> FETCH.
- HALT: absorbing; halted=1. Only reset leaves this state.
- Timeout: a wait counter clears on entry to each memory state and counts while mem_req=1 without mem_ack.
  - When it reaches MEM_TIMEOUT: bus_err=1 (sticky until reset), mem_req=0, go to HALT.
- mem_ack arriving outside a memory state is ignored.
- mem_req must not drop before mem_ack.
- The core never issues back-to-back requests without a one-cycle gap; the exception is FETCH->DECODE->IMM.

Test Plan:
- Reset asserted mid-FETCH with mem_req=1 -> all outputs 0 the same cycle; after release, FETCH with mem_req=1.
- ADD (op=0), ack latency 0 wait cycles -> FETCH(1), DECODE, EXEC ALUop=000 ALUsrc=1, WB RegW2=1 RegSrc=10; 4 cycles total, back to FETCH.
- LW (op=6), 3-cycle ack delay in IMM and in MEM -> writeImR pulse once; MEM mem_we=0 mem_addr_src=1; WB RegSrc=01; exactly two pc_write pulses.
- BEQ with cmp_result=1, then BNE with cmp_result=0 -> first: pc_write with pc_src=01 in BR; second: no pc_write in BR.
- SLT (op=4) -> WB_CR has writeCR=1 and RegW1=1; RegW2 stays 0.
- mem_ack withheld 15 cycles in MEM -> bus_err=1, mem_req=0, halted=1.
  - Later mem_ack and op changes are ignored until reset_n is pulsed low.
